pipeline_control: RTL and testbench

PIPELINE_CONTROL -- requirements
Module: pipeline_control

---
 rtl/pipeline_control.sv | 140 ++++++++++++++
 tb/tb_pipeline_control.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_control.sv
// Central hazard/stall controller for a five-stage pipeline: register enables, bubble flushes,
// data-miss freeze, sticky halt and a saturating stall-cycle counter.
module pipeline_control (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        mem_dREN,
    input  logic        mem_dWEN,
    input  logic        ex_dREN,
    input  logic [4:0]  ex_rt,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_branch_taken,
    input  logic        wb_halt,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        halted,
    output logic [15:0] stall_cycles,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;

    logic data_miss;
    logic load_use;

    assign data_miss = (mem_dREN | mem_dWEN) & ~dhit;
    assign load_use  = ex_dREN & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (ex_rt == id_rt));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= RUN;
            stall_cycles_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (wb_halt)
                    state_d = HALT;
                else if (data_miss)
                    state_d = DWAIT;
            end
            DWAIT: begin
                if (wb_halt)
                    state_d = HALT;
                else if (dhit)
                    state_d = RUN;
            end
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    // Stall events are mutually exclusive by priority; a flush overrides the hold on its register.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (!RST) begin
            case (state_q)
                RUN: begin
                    if (data_miss) begin
                        pc_en = 1'b0;
                    end else if (ex_branch_taken) begin
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (load_use) begin
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        idex_flush = 1'b1;
                    end else if (!ihit) begin
                        ifid_en    = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        ifid_flush = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        ifid_en  = 1'b1;
                        idex_en  = 1'b1;
                        exmem_en = 1'b1;
                        memwb_en = 1'b1;
                    end
                end
                DWAIT: begin
                    if (dhit) begin
                        pc_en    = 1'b1;
                        ifid_en  = 1'b1;
                        idex_en  = 1'b1;
                        exmem_en = 1'b1;
                        memwb_en = 1'b1;
                    end
                end
                default: pc_en = 1'b0;
            endcase
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (!pc_en && (state_q != HALT) && (stall_cycles_q != 16'hFFFF))
            stall_cycles_d = stall_cycles_q + 16'd1;
    end

    assign state        = state_q;
    assign halted       = (state_q == HALT);
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control: inputs change on the falling edge and outputs are
// sampled #1 later, so registered values reflect the preceding rising edge.
module tb_pipeline_control;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit, dhit, mem_dREN, mem_dWEN, ex_dREN;
    logic [4:0]  ex_rt, id_rs, id_rt;
    logic        ex_branch_taken, wb_halt;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush;
    logic        halted;
    logic [15:0] stall_cycles;
    logic [1:0]  state;

    int check_count = 0;
    int error_count = 0;

    logic [4:0] en;
    logic [2:0] fl;
    assign en = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
    assign fl = {ifid_flush, idex_flush, exmem_flush};

    pipeline_control dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .ex_dREN(ex_dREN),
        .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
        .ex_branch_taken(ex_branch_taken), .wb_halt(wb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .halted(halted), .stall_cycles(stall_cycles), .state(state)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst_i, input logic ihit_i, input logic dhit_i,
                                 input logic dren_i, input logic dwen_i, input logic exdren_i,
                                 input logic [4:0] exrt_i, input logic [4:0] idrs_i,
                                 input logic [4:0] idrt_i, input logic br_i, input logic halt_i);
        @(negedge CLK);
        RST             = rst_i;
        ihit            = ihit_i;
        dhit            = dhit_i;
        mem_dREN        = dren_i;
        mem_dWEN        = dwen_i;
        ex_dREN         = exdren_i;
        ex_rt           = exrt_i;
        id_rs           = idrs_i;
        id_rt           = idrt_i;
        ex_branch_taken = br_i;
        wb_halt         = halt_i;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        RST = 1'b1; ihit = 1'b1; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
        ex_dREN = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        ex_branch_taken = 1'b0; wb_halt = 1'b0;

        // Reset: outputs forced low, registered state cleared
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("rst_en", 32'(en), 32'h00);
        checkOutput("rst_fl", 32'(fl), 32'h0);
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        checkOutput("rst_stall", 32'(stall_cycles), 32'd0);

        idle();
        checkOutput("run_en", 32'(en), 32'h1F);
        checkOutput("run_fl", 32'(fl), 32'h0);

        // Data miss: three frozen cycles then the dhit cycle
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("dmiss1_en", 32'(en), 32'h00);
        checkOutput("dmiss1_state", 32'(state), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("dmiss2_en", 32'(en), 32'h00);
        checkOutput("dmiss2_fl", 32'(fl), 32'h0);
        checkOutput("dmiss2_state", 32'(state), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("dmiss3_en", 32'(en), 32'h00);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("dhit_en", 32'(en), 32'h1F);
        checkOutput("dhit_state", 32'(state), 32'd1);
        checkOutput("dhit_stall", 32'(stall_cycles), 32'd3);
        idle();
        checkOutput("dback_state", 32'(state), 32'd0);
        checkOutput("dback_stall", 32'(stall_cycles), 32'd3);

        // Load-use on rs: one bubble
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
        checkOutput("lu_rs_en", 32'(en), 32'h07);
        checkOutput("lu_rs_fl", 32'(fl), 32'h2);
        idle();
        checkOutput("lu_rs_stall", 32'(stall_cycles), 32'd4);
        checkOutput("lu_rs_after_en", 32'(en), 32'h1F);

        // Load-use on rt
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0);
        checkOutput("lu_rt_en", 32'(en), 32'h07);
        checkOutput("lu_rt_fl", 32'(fl), 32'h2);

        // Register zero never creates a hazard
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("lu_zero_en", 32'(en), 32'h1F);
        checkOutput("lu_zero_fl", 32'(fl), 32'h0);
        checkOutput("lu_rt_stall", 32'(stall_cycles), 32'd5);

        // Branch beats load-use
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        checkOutput("br_lu_en", 32'(en), 32'h1F);
        checkOutput("br_lu_fl", 32'(fl), 32'h6);
        idle();
        checkOutput("br_lu_stall", 32'(stall_cycles), 32'd5);

        // Instruction miss: fetch holds, IF/ID gets a bubble
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("imiss_en", 32'({pc_en, idex_en, exmem_en, memwb_en}), 32'h7);
        checkOutput("imiss_fl", 32'(fl), 32'h4);
        idle();
        checkOutput("imiss_stall", 32'(stall_cycles), 32'd6);

        // Data stall beats branch
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        checkOutput("dst_br_en", 32'(en), 32'h00);
        checkOutput("dst_br_fl", 32'(fl), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("dst_hit_en", 32'(en), 32'h1F);
        checkOutput("dst_hit_state", 32'(state), 32'd1);
        idle();
        checkOutput("dst_stall", 32'(stall_cycles), 32'd7);

        // Halt: sticky while inputs toggle
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        checkOutput("halt_req_en", 32'(en), 32'h1F);
        checkOutput("halt_req_halted", 32'(halted), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        checkOutput("halt_halted", 32'(halted), 32'd1);
        checkOutput("halt_state", 32'(state), 32'd2);
        checkOutput("halt_en", 32'(en), 32'h00);
        checkOutput("halt_fl", 32'(fl), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
        checkOutput("halt2_en", 32'(en), 32'h00);
        checkOutput("halt2_halted", 32'(halted), 32'd1);
        idle();
        checkOutput("halt_stall", 32'(stall_cycles), 32'd7);

        // Reset out of HALT
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("hrst_en", 32'(en), 32'h00);
        idle();
        checkOutput("hrst_halted", 32'(halted), 32'd0);
        checkOutput("hrst_state", 32'(state), 32'd0);
        checkOutput("hrst_stall", 32'(stall_cycles), 32'd0);

        // Reset in the middle of DWAIT
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("wrst_pre_state", 32'(state), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("wrst_en", 32'(en), 32'h00);
        checkOutput("wrst_fl", 32'(fl), 32'h0);
        idle();
        checkOutput("wrst_state", 32'(state), 32'd0);
        checkOutput("wrst_stall", 32'(stall_cycles), 32'd0);
        checkOutput("wrst_en_after", 32'(en), 32'h1F);

        // Saturation: 65534 stalled cycles, then three more
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        repeat (65534) @(negedge CLK);
        #1;
        checkOutput("sat_pre", 32'(stall_cycles), 32'hFFFE);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            #1;
            checkOutput($sformatf("sat_%0d", i), 32'(stall_cycles), 32'hFFFF);
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
